// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle between CTRL/ID, instruction memory and the PC generator.
// The fetch controller uses the master modport (it issues imem requests); the environment uses slave.
interface pc_fetch_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned EXC_W  = 32
);
   logic              stall;
   logic              flush;
   logic [ADDR_W-1:0] new_pc;
   logic              branch_flag_i;
   logic [ADDR_W-1:0] branch_tgt_i;
   logic              imem_ready;
   logic              imem_req;
   logic [ADDR_W-1:0] pc;
   logic              ce;
   logic [EXC_W-1:0]  excepttype_o;

   modport master (
      input  stall, flush, new_pc, branch_flag_i, branch_tgt_i, imem_ready,
      output imem_req, pc, ce, excepttype_o
   );

   modport slave (
      output stall, flush, new_pc, branch_flag_i, branch_tgt_i, imem_ready,
      input  imem_req, pc, ce, excepttype_o
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// IF-stage fetch-address generator: pc/ce registers, imem request handshake, flush/branch redirects.
// Define PC_FETCH_REDIRECT_BUF_EN to buffer a branch that arrives while fetch is held (enables S_PEND).
module pc_fetch_ctrl #(
   parameter int unsigned ADDR_W    = 32,
   parameter logic [31:0] RESET_VEC = 32'hBFC00000,
   parameter int unsigned INC_BYTES = 4,
   parameter int unsigned EXC_W     = 32,
   parameter int unsigned ADEL_BIT  = 4
) (
   input  logic       clk,
   input  logic       rst,
   pc_fetch_if.master bus
);
   localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
   localparam logic [ADDR_W-1:0] INC    = ADDR_W'(INC_BYTES);

   typedef enum logic [1:0] {S_OFF, S_RUN, S_PEND} state_t;

   state_t            state;
   logic              ce_q;
   logic [ADDR_W-1:0] pc_q;
   logic [EXC_W-1:0]  exc_q;
   logic              pend_v;
   logic [ADDR_W-1:0] pend_addr;

   logic              req;
   logic              advance;
   logic              pc_upd;
   logic [ADDR_W-1:0] pc_nxt;

   function automatic logic [EXC_W-1:0] adel_flags(input logic [ADDR_W-1:0] a);
      logic [EXC_W-1:0] f;
      f           = '0;
      f[ADEL_BIT] = |a[1:0];
      return f;
   endfunction

   // A misaligned pc must never reach memory; it sits until a flush replaces it.
   assign req     = ce_q & ~bus.stall & ~exc_q[ADEL_BIT];
   assign advance = req & bus.imem_ready;

   always_comb begin
      pc_upd = 1'b0;
      pc_nxt = pc_q;
      if (bus.flush) begin
         pc_upd = 1'b1;
         pc_nxt = bus.new_pc;
      end else if (advance) begin
         pc_upd = 1'b1;
         if (bus.branch_flag_i) begin
            pc_nxt = bus.branch_tgt_i;
         end else if (pend_v) begin
            pc_nxt = pend_addr;
         end else begin
            pc_nxt = pc_q + INC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_OFF;
         ce_q      <= 1'b0;
         pc_q      <= RST_PC;
         exc_q     <= '0;
         pend_v    <= 1'b0;
         pend_addr <= '0;
      end else begin
         case (state)
            S_OFF: begin
               // Enable only; the first fetch is issued from RST_PC itself.
               ce_q  <= 1'b1;
               pc_q  <= RST_PC;
               exc_q <= adel_flags(RST_PC);
               state <= S_RUN;
            end
            default: begin
               if (pc_upd) begin
                  pc_q   <= pc_nxt;
                  exc_q  <= adel_flags(pc_nxt);
                  pend_v <= 1'b0;
                  state  <= S_RUN;
               end else if (bus.branch_flag_i) begin
`ifdef PC_FETCH_REDIRECT_BUF_EN
                  // Held branch: remember the newest target until the next advance.
                  pend_addr <= bus.branch_tgt_i;
                  pend_v    <= 1'b1;
                  state     <= S_PEND;
`endif
               end
            end
         endcase
      end
   end

   assign bus.imem_req     = req;
   assign bus.pc           = pc_q;
   assign bus.ce           = ce_q;
   assign bus.excepttype_o = exc_q;
endmodule
